// File: rtl/reduce_unit.sv
// reduce_unit: time-multiplexed N-operand sum/max/min reduction over shared combiner lanes
module reduce_unit #(
    parameter int N      = 7,
    parameter int W      = 10,
    parameter int LANES  = 1,
    parameter int SIGNED = 0,
    localparam int OW    = W + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_enable,
    input  logic [1:0]        mode,
    input  logic [N*W-1:0]    operands,
    output logic              busy,
    output logic              w_enable,
    output logic [OW-1:0]     result
);
    localparam int LE = (LANES < N / 2) ? LANES : N / 2;
    localparam int MW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   slot [N];
    logic [OW-1:0]   ext  [N];
    logic [OW-1:0]   nxt  [N];
    logic [MW-1:0]   m, k, rem;
    logic [1:0]      mode_q;

    // ties keep a (lower-index operand); modes other than max/min add
    function automatic logic [OW-1:0] comb(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                           input logic [1:0] md);
        logic gt, lt;
        gt = (SIGNED != 0) ? ($signed(b) > $signed(a)) : (b > a);
        lt = (SIGNED != 0) ? ($signed(b) < $signed(a)) : (b < a);
        return (md == 2'd1) ? (gt ? b : a) : (md == 2'd2) ? (lt ? b : a) : a + b;
    endfunction

    // widen each operand to the result width
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (SIGNED != 0) ext[i] = OW'($signed(operands[i*W +: W]));
            else ext[i] = OW'(operands[i*W +: W]);
        end
    end

    // one reduction step: fold k pairs into the low slots, slide the untouched tail down by k
    always_comb begin
        k   = ((m >> 1) < MW'(LE)) ? (m >> 1) : MW'(LE);
        rem = m - k;
        for (int j = 0; j < N; j++) begin
            nxt[j] = slot[j];
            for (int s = 1; s <= LE && j + s < N; s++)
                if (k == MW'(s) && MW'(j) < rem) nxt[j] = slot[j+s];
        end
        for (int j = 0; j < LE; j++)
            if (MW'(j) < k) nxt[j] = comb(slot[2*j], slot[2*j+1], mode_q);
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    // a load always wins; RUN finishes on the step that leaves a single live slot
    always_comb begin
        state_nxt = state;
        if (r_enable) state_nxt = (N == 1) ? DONE : RUN;
        else if (state == RUN && rem == MW'(1)) state_nxt = DONE;
    end

    assign busy = (state == RUN);

    // operand slots, live count and published result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) slot[i] <= '0;
            m        <= '0;
            mode_q   <= '0;
            result   <= '0;
            w_enable <= 1'b0;
        end else if (r_enable) begin
            for (int i = 0; i < N; i++) slot[i] <= ext[i];
            m        <= MW'(N);
            mode_q   <= mode;
            w_enable <= (N == 1);
            if (N == 1) result <= ext[0];
        end else if (state == RUN) begin
            for (int i = 0; i < N; i++) slot[i] <= nxt[i];
            m <= rem;
            if (rem == MW'(1)) begin
                result   <= nxt[0];
                w_enable <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reduce_unit.sv
// tb_reduce_unit: scoreboard bench over three reduce_unit configurations
module tb_reduce_unit;
    typedef struct {
        logic [12:0] v;
        int          lc;
        int          lat;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  r_en = '0;
    logic [1:0]  md [3] = '{2'd0, 2'd0, 2'd0};
    logic [69:0] ops0 = '0, ops1 = '0;
    logic [7:0]  ops2 = '0;
    logic [2:0]  busy, wen;
    logic [12:0] res0, res1;
    logic [7:0]  res2;
    logic [12:0] resv [3];
    ent_t        q [3][$];
    ent_t        e;
    int          bcnt [3] = '{0, 0, 0};
    logic [2:0]  wprev = '0;
    int          cyc = 0;
    int          total = 0, passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reduce_unit #(.N(7), .W(10), .LANES(1), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .r_enable(r_en[0]), .mode(md[0]), .operands(ops0),
        .busy(busy[0]), .w_enable(wen[0]), .result(res0));
    reduce_unit #(.N(7), .W(10), .LANES(2), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .r_enable(r_en[1]), .mode(md[1]), .operands(ops1),
        .busy(busy[1]), .w_enable(wen[1]), .result(res1));
    reduce_unit #(.N(1), .W(8), .LANES(1), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .r_enable(r_en[2]), .mode(md[2]), .operands(ops2),
        .busy(busy[2]), .w_enable(wen[2]), .result(res2));

    assign resv[0] = res0;
    assign resv[1] = res1;
    assign resv[2] = {5'd0, res2};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [69:0] pk(input int a [7]);
        logic [69:0] r;
        for (int i = 0; i < 7; i++) r[i*10 +: 10] = a[i][9:0];
        return r;
    endfunction

    // monitor: every rising w_enable pops one expected entry
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (busy[d]) bcnt[d]++;
            if (wen[d] && !wprev[d]) begin
                if (q[d].size() == 0) begin
                    total++;
                    $display("FAIL unexpected_wen%0d: got result %0h with nothing pending", d, resv[d]);
                end else begin
                    e = q[d].pop_front();
                    chk($sformatf("result%0d", d), 32'(resv[d]), 32'(e.v));
                    chk($sformatf("latency%0d", d), cyc - e.lc, e.lat);
                    chk($sformatf("busy_cycles%0d", d), bcnt[d], e.lat);
                end
            end
        end
        wprev = wen;
    end

    task automatic load(input int d, input logic [69:0] ops, input logic [1:0] m,
                        input logic [12:0] v, input int lat);
        @(posedge clk); #1;
        if (d == 0) ops0 = ops; else if (d == 1) ops1 = ops; else ops2 = ops[7:0];
        md[d]   = m;
        r_en[d] = 1'b1;
        @(posedge clk); #1;
        r_en[d] = 1'b0;
        bcnt[d] = 0;
        q[d].delete();
        q[d].push_back('{v, cyc, lat});
        if (d != 2) chk($sformatf("wen_cleared%0d", d), 32'(wen[d]), 0);
        md[d] = ~m;
        if (d == 0) ops0 = ~ops0; else if (d == 1) ops1 = ~ops1; else ops2 = ~ops2;
    endtask

    task automatic wait_done(input int d, input logic [12:0] v);
        for (int t = 0; t < 40 && q[d].size() != 0; t++) @(posedge clk);
        if (q[d].size() != 0) begin
            total++;
            $display("FAIL timeout%0d: %0d results still pending", d, q[d].size());
            q[d].delete();
        end
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("hold_wen%0d", d), 32'(wen[d]), 1);
        chk($sformatf("hold_result%0d", d), 32'(resv[d]), 32'(v));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_wen", 32'(wen), 0);
        chk("reset_result0", 32'(res0), 0);
        rst = 1'b0;

        load(0, pk('{1, 2, 3, 4, 5, 6, 7}), 2'd0, 13'd28, 6);
        wait_done(0, 13'd28);
        load(0, pk('{1023, 1023, 1023, 1023, 1023, 1023, 1023}), 2'd0, 13'd7161, 6);
        wait_done(0, 13'd7161);
        load(0, pk('{4, 2, 7, 1, 7, 3, 5}), 2'd1, 13'd7, 6);
        wait_done(0, 13'd7);
        load(0, pk('{4, 2, 7, 1, 7, 3, 5}), 2'd2, 13'd1, 6);
        wait_done(0, 13'd1);

        load(1, pk('{-5, 3, -512, 511, 0, 7, -1}), 2'd1, 13'd511, 4);
        wait_done(1, 13'd511);
        load(1, pk('{-5, 3, -512, 511, 0, 7, -1}), 2'd2, 13'h1E00, 4);
        wait_done(1, 13'h1E00);
        load(1, pk('{-5, 3, -512, 511, 0, 7, -1}), 2'd3, 13'd3, 4);
        wait_done(1, 13'd3);

        load(0, pk('{1, 2, 3, 4, 5, 6, 7}), 2'd0, 13'd28, 6);
        @(posedge clk);
        load(0, pk('{2, 2, 2, 2, 2, 2, 2}), 2'd0, 13'd14, 6);
        wait_done(0, 13'd14);

        load(0, pk('{1, 2, 3, 4, 5, 6, 7}), 2'd0, 13'd28, 6);
        @(posedge clk); #2;
        rst = 1'b1;
        q[0].delete();
        #1;
        chk("midrun_rst_busy", 32'(busy[0]), 0);
        chk("midrun_rst_wen", 32'(wen[0]), 0);
        chk("midrun_rst_result", 32'(res0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        load(0, pk('{1, 2, 3, 4, 5, 6, 7}), 2'd0, 13'd28, 6);
        wait_done(0, 13'd28);

        load(2, 70'h0A5, 2'd0, 13'h0A5, 0);
        wait_done(2, 13'h0A5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
